// File: rtl/noc_pkg.sv
// Shared definitions for the mesh NoC router: frame layout, port labels and
// the output-stage state type used by every per-port output arbiter.
package noc_pkg;

    // Frame layout; hop counts and direction bits are only ever read upstream
    localparam int FRAME_W     = 64;
    localparam int PAYLOAD_LSB = 16;
    localparam int PAYLOAD_W   = FRAME_W - PAYLOAD_LSB;
    localparam int HX_LSB      = 1;
    localparam int HX_W        = 4;
    localparam int HY_LSB      = 5;
    localparam int HY_W        = 4;
    localparam int DIRX_BIT    = 9;
    localparam int DIRY_BIT    = 10;

    typedef logic [FRAME_W-1:0] frame_t;

    // Router port labels, used to name requesters and output channels
    typedef enum logic [2:0] {
        CW,
        CCW,
        SN,
        NS,
        PE
    } port_e;

    // Single-entry output stage occupancy
    typedef enum logic {
        EMPTY,
        FULL
    } out_state_e;

    // Payload field of a frame, handy for checking traffic end to end
    function automatic logic [PAYLOAD_W-1:0] frame_payload(input frame_t f);
        return f[FRAME_W-1:PAYLOAD_LSB];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester selector shared by all router output ports.
// Round-robin mode scans upward from the slot after the last winner with
// wrap-around; fixed mode always favours the lowest-numbered requester.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    input  logic               prio_mode,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    // Walk the candidates in search order and keep the first one requesting
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (prio_mode) begin
                cand = k;
            end else begin
                cand = int'(last) + 1 + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output-port arbiter of the mesh NoC router. Picks one requesting input
// port per cycle, registers its frame into a single-entry output stage and
// keeps saturating per-requester grant counters for fairness inspection.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = FRAME_W,
    parameter  int CNT_W   = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    input  logic                     prio_mode,
    input  logic                     cnt_clr,
    output logic [IDX_W-1:0]         grant_idx,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt
);

    out_state_e       state;
    logic [IDX_W-1:0] last;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             any;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] win_data;
    logic [CNT_W-1:0] cnt [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .last      (last),
        .prio_mode (prio_mode),
        .grant     (win_onehot),
        .grant_idx (win_idx),
        .any       (any)
    );

    // The stage can take a frame when empty or when its frame leaves this cycle;
    // nothing is offered while reset is held
    always_comb begin
        load_en   = (state == EMPTY) || out_ready;
        xfer      = any && load_en && rst_n;
        req_ready = xfer ? win_onehot : '0;
        win_data  = req_data[win_idx*WIDTH +: WIDTH];
    end

    // Output stage FSM with registered valid/data/index and the RR pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            grant_idx <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                        out_data  <= win_data;
                        grant_idx <= win_idx;
                        last      <= win_idx;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (xfer) begin
                            out_data  <= win_data;
                            grant_idx <= win_idx;
                            last      <= win_idx;
                        end else begin
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating grant counters; a clear wins over a coincident grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (xfer && (cnt[win_idx] != {CNT_W{1'b1}})) begin
            cnt[win_idx] <= cnt[win_idx] + 1'b1;
        end
    end

    // Flatten the counters onto the output bus
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_noc_output_arbiter;
    import noc_pkg::*;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int CW_BITS = 4;
    localparam int CNT_MAX = (1 << CW_BITS) - 1;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
    logic             prio_mode;
    logic             cnt_clr;
    logic [1:0]       grant_idx;
    logic [N*CW_BITS-1:0] grant_cnt;

    int checks;
    int errors;

    // Reference model state: what the output stage should hold
    bit          m_full;
    logic [63:0] m_data;
    int          m_idx;
    int          m_last;
    int          m_cnt [N];
    logic [N-1:0] m_acc;

    noc_output_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .CNT_W   (CW_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .prio_mode (prio_mode),
        .cnt_clr   (cnt_clr),
        .grant_idx (grant_idx),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input bit prio, input int last);
        int i;
        for (int k = 0; k < N; k++) begin
            i = prio ? k : (last + 1 + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_data = '0;
        m_idx  = 0;
        m_last = N - 1;
        m_acc  = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic set_req(input int i, input logic [63:0] d);
        req_valid[i] = 1'b1;
        req_data[i*W +: W] = d;
    endtask

    task automatic release_accepted();
        for (int i = 0; i < N; i++) if (m_acc[i]) req_valid[i] = 1'b0;
    endtask

    function automatic logic [63:0] frame(input logic [47:0] pay);
        return {pay, 16'($urandom)};
    endfunction

    // One clock: compare DUT with model mid-cycle, advance model, step past the edge
    task automatic tick();
        int win;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        if (!rst_n) model_reset();
        win = pick(req_valid, prio_mode, m_last);
        exp_ready = '0;
        if (rst_n && win >= 0 && (!m_full || out_ready)) exp_ready[win] = 1'b1;
        chk("out_valid", 64'(out_valid), 64'(m_full));
        chk("out_data", out_data, m_data);
        chk("grant_idx", 64'(grant_idx), 64'(m_idx));
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        for (int i = 0; i < N; i++)
            chk("grant_cnt", 64'(grant_cnt[i*CW_BITS +: CW_BITS]), 64'(m_cnt[i]));
        m_acc = exp_ready;
        if (rst_n) begin
            if (exp_ready != 0) begin
                m_full = 1;
                m_data = req_data[win*W +: W];
                m_idx  = win;
                m_last = win;
                if (!cnt_clr && m_cnt[win] < CNT_MAX) m_cnt[win]++;
            end else if (m_full && out_ready) begin
                m_full = 0;
            end
            if (cnt_clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        bit seen2;
        // reset
        rst_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b1;
        prio_mode = 1'b0; cnt_clr = 1'b0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;

        // all four requesters at once, round-robin from index 0
        for (int i = 0; i < N; i++) set_req(i, frame(48'h1111_1111_1111 * (i + 1)));
        for (int k = 0; k < N; k++) begin
            tick();
            release_accepted();
            chk("rr_payload", 64'(frame_payload(out_data)), 64'(48'h1111_1111_1111 * (k + 1)));
            chk("rr_idx", 64'(grant_idx), 64'(k));
        end
        for (int i = 0; i < N; i++) chk("rr_cnt", 64'(grant_cnt[i*CW_BITS +: CW_BITS]), 64'd1);
        tick();

        // clear counters, then single requester 1
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        set_req(1, frame(48'h2222_2222_2222));
        tick(); release_accepted();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_payload", 64'(frame_payload(out_data)), 64'h2222_2222_2222);
        chk("single_idx", 64'(grant_idx), 64'd1);
        chk("single_cnt", 64'(grant_cnt[CW_BITS +: CW_BITS]), 64'd1);
        tick();

        // backpressure holding 1111 from requester 0
        set_req(0, frame(48'h1111_1111_1111));
        tick(); release_accepted();
        out_ready = 1'b0;
        set_req(0, frame(48'h5555_5555_5555));
        set_req(1, frame(48'h6666_6666_6666));
        repeat (5) begin
            tick();
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_payload", 64'(frame_payload(out_data)), 64'h1111_1111_1111);
        end
        out_ready = 1'b1;
        tick(); release_accepted();
        chk("bp_next_idx", 64'(grant_idx), 64'd1);
        tick(); release_accepted();
        tick();

        // fixed priority: requester 0 starves requester 2
        prio_mode = 1'b1;
        set_req(2, frame(48'h3333_3333_3333));
        for (int k = 0; k < 8; k++) begin
            set_req(0, frame(48'h1111_0000_0000 + 48'(k)));
            tick();
            chk("fixed_idx", 64'(grant_idx), 64'd0);
            chk("fixed_req2_held", 64'(req_valid[2] & ~m_acc[2]), 64'd1);
        end
        prio_mode = 1'b0;
        seen2 = 0;
        repeat (2) begin
            if (m_acc[0]) set_req(0, frame(48'h1111_0000_00FF));
            tick();
            if (grant_idx == 2'd2) seen2 = 1;
            if (m_acc[2]) req_valid[2] = 1'b0;
        end
        chk("rr_after_fixed", 64'(seen2), 64'd1);
        req_valid = '0;
        tick(); tick();

        // counter saturation and clear-over-increment
        for (int k = 0; k < 20; k++) begin
            set_req(3, frame(48'h4444_0000_0000 + 48'(k)));
            tick();
        end
        chk("sat_cnt", 64'(grant_cnt[3*CW_BITS +: CW_BITS]), 64'(CNT_MAX));
        cnt_clr = 1'b1;
        set_req(3, frame(48'h4444_FFFF_0000));
        tick();
        cnt_clr = 1'b0;
        chk("clr_accepted", 64'(m_acc[3]), 64'd1);
        chk("clr_cnt", 64'(grant_cnt[3*CW_BITS +: CW_BITS]), 64'd0);
        req_valid = '0;
        tick();

        // reset while the output stage is full
        set_req(1, frame(48'h7777_7777_7777));
        tick(); release_accepted();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, frame(48'h1111_1111_1111 * (i + 1)));
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(); release_accepted();
        chk("rst_first_idx", 64'(grant_idx), 64'd0);
        repeat (4) begin tick(); release_accepted(); end

        // randomized traffic obeying the hold-until-accepted rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_acc[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_data[i*W +: W] = {$urandom, $urandom};
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) prio_mode = ~prio_mode;
            cnt_clr = ($urandom_range(0, 40) == 0);
            tick();
        end
    endtask

    task automatic checkOutput();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        applyStimulus();
        checkOutput();
        $finish;
    end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Clocked per-output-port arbiter for the mesh NoC router.
- Shares one router output channel (CW, CCW, SN, NS or PE) between up to NUM_REQ input ports that route packets to it.
- Selects one winner per cycle (round-robin or fixed priority) and registers the 64-bit frame into a single-entry output stage.
- Keeps saturating per-requester grant counters, so fairness is visible in simulation.

Parameters:
- NUM_REQ, 4, number of competing input ports (>=2).
- WIDTH, 64, packet frame width; frames pass through unmodified.
- CNT_W, 16, width of each per-requester grant counter.
- IDX_W, $clog2(NUM_REQ), width of the grant index (localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester frame valid.
- req_data  in  NUM_REQ*WIDTH  flattened frames; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- out_valid  out  1  output stage holds a frame.
- out_data  out  WIDTH  registered frame.
- out_ready  in  1  downstream accepts the frame.
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- cnt_clr  in  1  synchronous clear of all grant counters.
- grant_idx  out  IDX_W  index of the requester that filled the current out_data.
- grant_cnt  out  NUM_REQ*CNT_W  flattened saturating grant counters.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - out_valid=0, out_data=0, grant_idx=0.
  - All grant_cnt=0.
  - RR pointer last=NUM_REQ-1, so the first search starts at index 0.
  - req_ready=0 while rst_n=0.
- Output stage FSM has two states, EMPTY and FULL.
  - load_en = EMPTY | (FULL & out_ready).
- Arbitration (combinational):
  - any = |req_valid.
  - RR mode: winner is the first i with req_valid[i]=1, scanning (last+1) mod NUM_REQ upward with wrap.
  - Fixed mode: winner is the lowest i with req_valid[i]=1.
- req_ready[winner] = any & load_en; all other bits are 0.
  - req_ready never depends on the same requester's req_data.
- Transfer occurs when req_valid[i] & req_ready[i]. On that clock edge:
  - out_data <= req_data[winner], grant_idx <= winner, out_valid <= 1.
  - last <= winner (updated in both modes).
  - grant_cnt[winner] increments, saturating at 2^CNT_W-1.
- Latency: 1 cycle from accepted request to out_valid. Throughput: 1 frame per cycle when out_ready is held high.
- FSM transitions:
  - EMPTY: stays EMPTY with no request; goes FULL on a transfer.
  - FULL with out_ready=0: stays FULL; out_data and grant_idx held stable; all req_ready=0.
  - FULL with out_ready=1 and a transfer: stays FULL with the new frame (back-to-back).
  - FULL with out_ready=1 and no request: goes EMPTY; out_valid=0 next cycle; out_data retains its last value.
- Requester rules:
  - Once req_valid is asserted, it and req_data are held until accepted. A violation is a bench assertion error.
  - Deasserting an unaccepted request is illegal.
- prio_mode changes take effect at the next arbitration; last is preserved across mode changes.
- Counters:
  - cnt_clr=1 zeroes all counters that cycle and has priority over a simultaneous increment; that grant is not counted.
  - Counters saturate and do not wrap.
- Reset mid-operation: a frame in the output stage is discarded (out_valid drops immediately, asynchronously) and the pointer returns to its reset value.
- Frame content (hop fields [8:1], dir [10:9], payload [63:16]) is not inspected or altered; routing decisions are made upstream.

Decomposition:
- Shared package noc_pkg:
  - FRAME_W=64, PAYLOAD_LSB=16, HX/HY/DIRX/DIRY bit positions.
  - typedef frame_t.
  - typedef port_e {CW, CCW, SN, NS, PE} for requester labelling.
- Sub-module rr_arbiter (NUM_REQ): takes req vector, last pointer and prio_mode; produces one-hot grant and index. Reused by the other four output ports.

Test Plan:
- Single requester: req 1 sends payload 2222_2222_2222 with out_ready=1 -> out_valid next cycle, out_data[63:16]=2222_2222_2222, grant_idx=1, grant_cnt[1]=1.
- All four requesters valid at once (1111..4444 on 0..3), RR, out_ready=1 -> outputs 1111, 2222, 3333, 4444 on consecutive cycles; each grant_cnt=1.
- Backpressure: output FULL with 1111, out_ready=0 for 5 cycles -> out_data stable, req_ready=0; on release next winner is 1 (not 0).
- Fixed priority: prio_mode=1, req0 continuously valid, req2 valid -> req0 wins every cycle for 8 cycles, req2 never accepted; switch to RR -> req2 granted within 2 transfers.
- Counter saturation/clear: CNT_W=4, 20 grants to req3 -> grant_cnt[3]=15; cnt_clr asserted in the same cycle as a grant -> 0.
- Reset mid-stream: assert rst_n=0 while FULL -> out_valid=0 immediately; after release, all four valid -> req0 granted first.
